// File: rtl/sha2_256_unrolled_core.sv
// SHA-224/SHA-256 compression core.
// Takes one 512-bit block per ready/valid handshake and runs ROUNDS_PER_CYCLE
// chained rounds per clock. The chaining value H can be preloaded with a
// stored midstate through iv_load.
module sha2_256_unrolled_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int ENABLE_224       = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic         in_first,
  input  logic         in_mode,
  input  logic         iv_load,
  input  logic [255:0] iv_in,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         done,
  output logic         busy
);

  localparam int R  = ROUNDS_PER_CYCLE;
  localparam int N  = 64 / R;
  // The counter also has to hold N: the feed-forward addition gets its own cycle.
  localparam int CW = $clog2(N + 1);

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          mode_q;     // mode of the block in flight
  logic          dmode_q;    // mode of the result currently shown on digest
  logic          first_q;    // block in flight chains from the mode IV
  logic          dvalid_q;
  logic [31:0]   h_q [8];    // chaining value
  logic [31:0]   v_q [8];    // working variables a..h
  logic [31:0]   w_q [16];   // message schedule window, w_q[0] = W[t]
  logic [31:0]   v_d [8];
  logic [31:0]   w_d [16];
  logic [31:0]   base [8];   // feed-forward operand
  logic [31:0]   seed_iv [8];
  logic          sel_224;

  assign sel_224  = (ENABLE_224 != 0) && in_mode;
  assign in_ready = (state_q != S_RUN) && !iv_load;
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign digest_valid = dvalid_q;

  // Per-word feed-forward base, IV seed and digest packing; SHA-224 hides H7.
  for (genvar gi = 0; gi < 8; gi++) begin : g_word
    assign base[gi]    = first_q ? (mode_q ? IV224[gi] : IV256[gi]) : h_q[gi];
    assign seed_iv[gi] = sel_224 ? IV224[gi] : IV256[gi];
    if (gi == 7) begin : g_last
      assign digest[31:0] = dmode_q ? 32'h0 : h_q[7];
    end else begin : g_mid
      assign digest[255-32*gi -: 32] = h_q[gi];
    end
  end

  // R chained rounds plus R new schedule words, computed from the registered window.
  always_comb begin : round_logic
    logic [31:0] ext [16+R];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    logic [5:0]  kidx;
    kidx = '0;
    for (int i = 0; i < 16; i++) ext[i] = w_q[i];
    // Words beyond the window may depend on words produced earlier in this same clock.
    for (int j = 0; j < R; j++)
      ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
    for (int i = 0; i < 16; i++) w_d[i] = ext[i+R];
    a = v_q[0]; b = v_q[1]; c = v_q[2]; d = v_q[3];
    e = v_q[4]; f = v_q[5]; g = v_q[6]; h = v_q[7];
    for (int j = 0; j < R; j++) begin
      kidx = 6'((int'(cnt_q) * R) + j);
      t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + K[kidx] + ext[j];
      t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    v_d[0] = a; v_d[1] = b; v_d[2] = c; v_d[3] = d;
    v_d[4] = e; v_d[5] = f; v_d[6] = g; v_d[7] = h;
  end

  // Control FSM with the datapath registers it loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      dmode_q  <= 1'b0;
      first_q  <= 1'b0;
      dvalid_q <= 1'b0;
      h_q      <= IV256;
      for (int i = 0; i < 8; i++)  v_q[i] <= '0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (cnt_q == CW'(N)) begin
            // Rounds finished on the previous edge; this edge only adds the base back in.
            for (int i = 0; i < 8; i++) h_q[i] <= base[i] + v_q[i];
            dmode_q  <= mode_q;
            dvalid_q <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            v_q   <= v_d;
            w_q   <= w_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          // IDLE and DONE behave alike; iv_load wins because it drops in_ready.
          if (iv_load) begin
            for (int i = 0; i < 8; i++) h_q[i] <= iv_in[255-32*i -: 32];
            dvalid_q <= 1'b0;
            state_q  <= S_IDLE;
          end else if (in_valid) begin
            for (int i = 0; i < 16; i++) w_q[i] <= in_block[511-32*i -: 32];
            first_q  <= in_first;
            if (in_first) begin
              mode_q <= sel_224;
              v_q    <= seed_iv;
            end else begin
              v_q    <= h_q;
            end
            cnt_q    <= '0;
            dvalid_q <= 1'b0;
            state_q  <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha2_256_unrolled_core.sv
// Self-checking bench for sha2_256_unrolled_core: a scoreboard of expected
// digests is filled as blocks are offered and drained on every done pulse.
module tb_sha2_256_unrolled_core;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0, in_valid4 = 1'b0;
  logic         in_first = 1'b0, in_mode = 1'b0;
  logic         iv_load = 1'b0, iv_load4 = 1'b0;
  logic [511:0] in_block = '0;
  logic [255:0] iv_in = '0;
  logic         in_ready, digest_valid, done, busy;
  logic         in_ready4, digest_valid4, done4, busy4;
  logic [255:0] digest, digest4;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_acc = 0;
  int last_acc = 0;
  logic [255:0] exp_q [$];

  sha2_256_unrolled_core #(.ROUNDS_PER_CYCLE(1), .ENABLE_224(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .in_first(in_first), .in_mode(in_mode),
    .iv_load(iv_load), .iv_in(iv_in), .digest(digest),
    .digest_valid(digest_valid), .done(done), .busy(busy));

  sha2_256_unrolled_core #(.ROUNDS_PER_CYCLE(4), .ENABLE_224(1)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_block(in_block), .in_first(in_first), .in_mode(in_mode),
    .iv_load(iv_load4), .iv_in(iv_in), .digest(digest4),
    .digest_valid(digest_valid4), .done(done4), .busy(busy4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard drain on done, latency measured from the accepting edge.
  always @(negedge clk) begin : monitor
    logic [255:0] e;
    if (!reset) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 256'(done), 256'(0));
        end else begin
          e = exp_q.pop_front();
          $display("txn done at cycle %0d digest=%h", cyc, digest);
          check("digest", digest, e);
          check("digest_valid", 256'(digest_valid), 256'(1));
          check("latency", 256'(cyc - last_acc), 256'(65));
        end
      end
      if (in_valid && in_ready) begin
        last_acc = cyc + 1;
        n_acc++;
      end
    end
  end

  task automatic send(input logic [511:0] blk, input logic first, input logic mode,
                      input logic [255:0] exp);
    int t;
    t = 0;
    @(posedge clk); #1;
    in_block = blk; in_first = first; in_mode = mode; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    check("accept_wait", 256'(t < 200), 256'(1));
    exp_q.push_back(exp);
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin @(negedge clk); t++; end
    check("idle_wait", 256'(t < 300), 256'(1));
    @(negedge clk);
  endtask

  initial begin
    logic [511:0] abc, b1, b2;
    logic [255:0] iv256, d_abc, d_224, mid, d_two;
    int n;
    abc   = {32'h61626380, {14{32'h0}}, 32'h00000018};
    b1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
             32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
             32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
             32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    b2    = {{15{32'h0}}, 32'h000001c0};
    iv256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    d_abc = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    d_224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
    mid   = 256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
    d_two = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 256'(in_ready), 256'(1));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_dv", 256'(digest_valid), 256'(0));
    check("rst_digest", digest, iv256);

    // SHA-256 "abc", with in_valid held during RUN
    send(abc, 1'b1, 1'b0, d_abc);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("run_in_ready", 256'(in_ready), 256'(0));
      check("run_busy", 256'(busy), 256'(1));
    end
    @(posedge clk); #1 in_valid = 1'b0;
    wait_idle();
    check("idle_dv", 256'(digest_valid), 256'(1));
    check("idle_digest", digest, d_abc);

    // SHA-224 "abc"
    send(abc, 1'b1, 1'b1, d_224);
    wait_idle();

    // Two-block message, second block offered through RUN and taken in DONE
    send(b1, 1'b1, 1'b0, mid);
    in_block = b2; in_first = 1'b0; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!done && n < 200) begin @(negedge clk); n++; end
    check("b2b_ready_in_done", 256'(in_ready), 256'(1));
    exp_q.push_back(d_two);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("b2b_busy", 256'(busy), 256'(1));
    check("b2b_dv_clear", 256'(digest_valid), 256'(0));
    wait_idle();

    // Midstate load with a competing in_valid that must be refused
    @(posedge clk); #1;
    iv_load = 1'b1; iv_in = mid; in_valid = 1'b1; in_block = b2; in_first = 1'b0;
    @(negedge clk);
    check("ivload_ready", 256'(in_ready), 256'(0));
    @(posedge clk); #1 iv_load = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("ivload_digest", digest, mid);
    check("ivload_dv", 256'(digest_valid), 256'(0));
    check("ivload_busy", 256'(busy), 256'(0));
    send(b2, 1'b0, 1'b0, d_two);
    wait_idle();

    // Reset around round 20 aborts the block
    @(posedge clk); #1;
    in_block = abc; in_first = 1'b1; in_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_digest", digest, iv256);
    check("abort_dv", 256'(digest_valid), 256'(0));
    check("abort_in_ready", 256'(in_ready), 256'(1));
    check("abort_busy", 256'(busy), 256'(0));
    n = 0;
    repeat (80) begin @(negedge clk); if (done) n++; end
    check("abort_no_done", 256'(n), 256'(0));
    check("accept_count", 256'(n_acc), 256'(6));

    // Four rounds per clock: 17-cycle latency, same digest
    @(posedge clk); #1;
    in_block = abc; in_first = 1'b1; in_mode = 1'b0; in_valid4 = 1'b1;
    @(posedge clk); #1 in_valid4 = 1'b0;
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (!done4 && n < 100);
    $display("txn r4 done after %0d cycles digest=%h", n, digest4);
    check("r4_latency", 256'(n), 256'(17));
    check("r4_digest", digest4, d_abc);
    check("r4_dv", 256'(digest_valid4), 256'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
